// File: rtl/sprite_motion_sched.sv
// Per-frame scheduler that walks the enabled sprites and issues one motion
// command per sprite to a shared datapath. Optional macro: KEY_STEER_EN.
module sprite_motion_sched #(
  parameter int N_SPRITES = 4,
  parameter int ID_W      = $clog2(N_SPRITES)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 vsync,
  input  logic [7:0]           keycode,
  input  logic [N_SPRITES-1:0] enable_mask,
  output logic                 upd_valid,
  output logic [ID_W-1:0]      upd_id,
  output logic [2:0]           upd_cmd,
  input  logic                 upd_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

  localparam logic [2:0] CMD_HOLD  = 3'b000;
  localparam logic [2:0] CMD_UP    = 3'b001;
  localparam logic [2:0] CMD_DOWN  = 3'b010;
  localparam logic [2:0] CMD_LEFT  = 3'b011;
  localparam logic [2:0] CMD_RIGHT = 3'b100;

  state_t                 state;
  logic                   vsync_q;
  logic                   armed;
  logic [N_SPRITES-1:0]   mask_q;
  logic [ID_W-1:0]        idx;
  logic                   frame_start;
  logic                   found;
  logic [ID_W-1:0]        sel;
  logic [2:0]             sel_cmd;
  logic                   last_id;

  // armed blocks a vsync that was already high at reset release from
  // counting as an edge until it has been seen low at least once.
  assign frame_start = vsync & ~vsync_q & armed;
  assign last_id     = (upd_id == ID_W'(N_SPRITES - 1));

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < N_SPRITES; i++) begin
      if (!found && mask_q[i] && (i >= 32'(idx))) begin
        found = 1'b1;
        sel   = ID_W'(i);
      end
    end
  end

`ifdef KEY_STEER_EN
  logic [7:0] key_q;

  function automatic logic [2:0] steer(input logic [7:0] k);
    case (k)
      8'h1A:   return CMD_UP;
      8'h16:   return CMD_DOWN;
      8'h04:   return CMD_LEFT;
      8'h07:   return CMD_RIGHT;
      default: return CMD_HOLD;
    endcase
  endfunction

  assign sel_cmd = (sel == '0) ? steer(key_q) : CMD_HOLD;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      key_q <= '0;
    else if (state == IDLE && frame_start)
      key_q <= keycode;
  end
`else
  logic unused_keycode;

  assign unused_keycode = ^keycode;
  assign sel_cmd        = CMD_HOLD;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      armed      <= 1'b0;
      mask_q     <= '0;
      idx        <= '0;
      upd_valid  <= 1'b0;
      upd_id     <= '0;
      upd_cmd    <= CMD_HOLD;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      armed      <= armed | ~vsync;
      frame_done <= 1'b0;

      // set is written last so it wins over a coincident clear
      if (clr_overrun)
        overrun <= 1'b0;
      if (frame_start && busy)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            mask_q <= enable_mask;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (found) begin
            upd_id    <= sel;
            upd_cmd   <= sel_cmd;
            upd_valid <= 1'b1;
            state     <= ISSUE;
          end else begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        ISSUE: begin
          if (upd_ready) begin
            upd_valid <= 1'b0;
            if (last_id) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx   <= upd_id + ID_W'(1);
              state <= SCAN;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_sched.sv
// Self-checking bench for sprite_motion_sched: vector table, randomized frames
// against a per-frame reference model, plus overrun and reset sequences.
module tb_sprite_motion_sched;

  localparam int N = 4;

`ifdef KEY_STEER_EN
  localparam bit STEER = 1'b1;
`else
  localparam bit STEER = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         vsync;
  logic [7:0]   keycode;
  logic [N-1:0] enable_mask;
  logic         upd_valid;
  logic [1:0]   upd_id;
  logic [2:0]   upd_cmd;
  logic         upd_ready;
  logic         busy;
  logic         frame_done;
  logic         overrun;
  logic         clr_overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sprite_motion_sched #(.N_SPRITES(N)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vsync(vsync), .keycode(keycode),
    .enable_mask(enable_mask), .upd_valid(upd_valid), .upd_id(upd_id),
    .upd_cmd(upd_cmd), .upd_ready(upd_ready), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] key;
    int         stall;
    int         exp_hs;
    int         exp_lat;
    logic [2:0] exp_cmd0;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int model_cmd(input int id, input logic [7:0] k);
    if (id != 0 || !STEER) return 0;
    case (k)
      8'h1A:   return 1;
      8'h16:   return 2;
      8'h04:   return 3;
      8'h07:   return 4;
      default: return 0;
    endcase
  endfunction

  // Runs one frame; stall<0 means random ready, extra_at>=2 re-pulses vsync mid-frame.
  task automatic run_frame(input logic [3:0] m, input logic [7:0] k, input int stall,
                           input int extra_at, input logic clr_with,
                           output int lat, output int lows, output int first_cmd);
    int exp_id[$];
    int exp_cmd[$];
    int hs, cur, e, busy_cnt, model_lat;
    bit seen, go;
    logic pv, pr;
    logic [1:0] pid;
    logic [2:0] pcmd;
    for (int i = 0; i < N; i++)
      if (m[i]) begin
        exp_id.push_back(i);
        exp_cmd.push_back(model_cmd(i, k));
      end
    @(negedge Clk);
    e = cyc;
    enable_mask = m;
    keycode = k;
    vsync = 1'b1;
    seen = 0; hs = 0; cur = 0; lows = 0; busy_cnt = 0; lat = -1; first_cmd = -1;
    pv = 1'b0; pr = 1'b0; pid = '0; pcmd = '0;
    for (int j = 0; j < 400 && !seen; j++) begin
      @(negedge Clk);
      if (j == 0) vsync = 1'b0;
      enable_mask = 4'($urandom);
      keycode = 8'($urandom);
      if (j == extra_at) begin
        vsync = 1'b1;
        clr_overrun = clr_with;
      end else if (j == extra_at + 1) begin
        vsync = 1'b0;
        clr_overrun = 1'b0;
      end
      if (pv && !pr) begin
        check("stall_valid", 32'(upd_valid), 1);
        check("stall_id", 32'(upd_id), 32'(pid));
        check("stall_cmd", 32'(upd_cmd), 32'(pcmd));
      end
      if (busy) busy_cnt++;
      if (frame_done) begin
        seen = 1;
        lat = cyc - e;
      end
      if (upd_valid) begin
        if (stall < 0) go = ($urandom_range(0, 1) == 1) || cur >= 3;
        else go = (cur >= stall);
        if (go) begin
          upd_ready = 1'b1;
          if (hs < exp_id.size()) begin
            check("hs_id", 32'(upd_id), 32'(exp_id[hs]));
            check("hs_cmd", 32'(upd_cmd), 32'(exp_cmd[hs]));
          end
          if (hs == 0) first_cmd = int'(upd_cmd);
          hs++;
          cur = 0;
        end else begin
          upd_ready = 1'b0;
          cur++;
          lows++;
        end
      end else begin
        upd_ready = (stall == 0);
      end
      pv = upd_valid; pr = upd_ready; pid = upd_id; pcmd = upd_cmd;
    end
    vsync = 1'b0;
    clr_overrun = 1'b0;
    check("frame_done_seen", 32'(seen), 1);
    check("handshakes", hs, exp_id.size());
    model_lat = 2 * exp_id.size() + lows + 1 + (m[N-1] ? 0 : 1);
    check("busy_cycles", busy_cnt, model_lat);
    @(negedge Clk);
    check("post_done_pulse", 32'(frame_done), 0);
    check("post_busy", 32'(busy), 0);
    check("post_valid", 32'(upd_valid), 0);
  endtask

  initial begin
    int lat, lows, fc;
    logic [3:0] m;
    logic [7:0] k;
    logic [7:0] keys[5];
    bit found;

    keys = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h00};
    tbl[0] = '{4'b1111, 8'h1A, 0, 4, 9,  STEER ? 3'd1 : 3'd0};
    tbl[1] = '{4'b1010, 8'h07, 3, 2, 11, 3'd0};
    tbl[2] = '{4'b0000, 8'h1A, 0, 0, 2,  3'd0};
    tbl[3] = '{4'b0001, 8'h16, 0, 1, 4,  STEER ? 3'd2 : 3'd0};
    tbl[4] = '{4'b0001, 8'h04, 0, 1, 4,  STEER ? 3'd3 : 3'd0};
    tbl[5] = '{4'b0001, 8'h07, 0, 1, 4,  STEER ? 3'd4 : 3'd0};
    tbl[6] = '{4'b0001, 8'h55, 0, 1, 4,  3'd0};
    tbl[7] = '{4'b1000, 8'h1A, 0, 1, 3,  3'd0};
    tbl[8] = '{4'b0110, 8'h1A, 1, 2, 8,  3'd0};
    tbl[9] = '{4'b0101, 8'h1A, 2, 2, 10, STEER ? 3'd1 : 3'd0};

    Reset_n = 1'b0; vsync = 1'b1; keycode = '0; enable_mask = '0;
    upd_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_valid", 32'(upd_valid), 0);
    check("rst_id", 32'(upd_id), 0);
    check("rst_cmd", 32'(upd_cmd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);

    // vsync high across reset release must not start a frame
    Reset_n = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      check("vsync_held_busy", 32'(busy), 0);
    end
    vsync = 1'b0;
    @(negedge Clk);

    for (int t = 0; t < 10; t++) begin
      run_frame(tbl[t].mask, tbl[t].key, tbl[t].stall, -1, 1'b0, lat, lows, fc);
      check($sformatf("tbl%0d_lat", t), lat, tbl[t].exp_lat);
      if (tbl[t].mask[0]) check($sformatf("tbl%0d_cmd0", t), fc, 32'(tbl[t].exp_cmd0));
    end
    check("overrun_clean", 32'(overrun), 0);

    for (int r = 0; r < 25; r++) begin
      m = 4'($urandom);
      k = keys[$urandom_range(0, 4)];
      run_frame(m, k, -1, -1, 1'b0, lat, lows, fc);
      check("rand_lat", lat, 2 * $countones(m) + lows + 1 + (m[N-1] ? 0 : 1));
    end

    run_frame(4'b1111, 8'h1A, 4, 3, 1'b0, lat, lows, fc);
    check("ovr_lat", lat, 25);
    check("ovr_set", 32'(overrun), 1);
    run_frame(4'b0001, 8'h1A, 4, 3, 1'b1, lat, lows, fc);
    check("ovr_lat2", lat, 8);
    check("ovr_set_wins", 32'(overrun), 1);
    clr_overrun = 1'b1;
    @(negedge Clk);
    clr_overrun = 1'b0;
    check("ovr_clear", 32'(overrun), 0);

    // reset asserted mid-ISSUE on id 2
    upd_ready = 1'b0;
    enable_mask = 4'b0100;
    keycode = 8'h1A;
    vsync = 1'b1;
    @(negedge Clk);
    vsync = 1'b0;
    found = 0;
    for (int j = 0; j < 20 && !found; j++) begin
      if (upd_valid && upd_id == 2'd2) found = 1;
      else @(negedge Clk);
    end
    check("rst_issue_reached", 32'(found), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("async_valid_drop", 32'(upd_valid), 0);
    check("async_busy_drop", 32'(busy), 0);
    repeat (3) begin
      @(negedge Clk);
      check("rst_no_done", 32'(frame_done), 0);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    run_frame(4'b1111, 8'h1A, 0, -1, 1'b0, lat, lows, fc);
    check("restart_lat", lat, 9);
    check("restart_cmd0", fc, STEER ? 1 : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_motion_sched.md
SPRITE_MOTION_SCHED -- requirements
Module: sprite_motion_sched

Interface
REQ-001 Parameter: N_SPRITES, 4, number of sprites sharing the motion-update datapath (range 2..8).
REQ-002 Parameter: ID_W, $clog2(N_SPRITES), width of the sprite index.
REQ-003 Port: Clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: Reset_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: vsync  input  1  synchronous level; each rising edge marks one frame start.
REQ-006 Port: keycode  input  8  USB HID keycode of the player's current key.
REQ-007 Port: enable_mask  input  N_SPRITES  bit i=1 means sprite i is updated this frame.
REQ-008 Port: upd_valid  output  1  update request to the shared motion datapath.
REQ-009 Port: upd_id  output  ID_W  index of the sprite being updated.
REQ-010 Port: upd_cmd  output  3  motion command: 000 HOLD, 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT.
REQ-011 Port: upd_ready  input  1  datapath accepts the request when high with upd_valid.
REQ-012 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 Port: frame_done  output  1  one-cycle pulse when all enabled sprites are updated.
REQ-014 Port: overrun  output  1  sticky flag for a frame start that arrives while busy.
REQ-015 Port: clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-016 The block SHALL detect a frame start as vsync=1 with the registered vsync=0.
REQ-017 The FSM SHALL have the states IDLE, SCAN, ISSUE and DONE.
REQ-018 On a frame start in IDLE, the block SHALL capture enable_mask and keycode, clear the index to 0, and enter SCAN on the next cycle.
REQ-019 In SCAN, the block SHALL select the lowest enabled index >= the current index, load upd_id and upd_cmd, and go to ISSUE; if no such index exists, it SHALL go to DONE.
REQ-020 In ISSUE, upd_valid SHALL be 1 and upd_id and upd_cmd SHALL stay stable until the cycle in which upd_ready=1.
REQ-021 On the ISSUE handshake, the index SHALL become upd_id+1 and the FSM SHALL return to SCAN, or go to DONE if upd_id=N_SPRITES-1.
REQ-022 In DONE, frame_done SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-023 Latency: with upd_ready tied high, each enabled sprite SHALL cost 2 cycles (SCAN+ISSUE); an empty mask SHALL pulse frame_done 2 cycles after the edge cycle.
REQ-024 The command for sprite 0 SHALL follow REQ-031/032; every other sprite SHALL receive HOLD.
REQ-025 A frame start while busy SHALL set overrun, SHALL be ignored, and SHALL NOT restart or perturb the sequence.
REQ-026 If overrun set and clr_overrun coincide in one cycle, set SHALL win.
REQ-027 upd_valid SHALL be 0 in IDLE, SCAN and DONE; changes to the live enable_mask or keycode mid-frame SHALL have no effect.

Reset
REQ-028 Reset_n=0 SHALL asynchronously force: state IDLE, upd_valid=0, upd_id=0, upd_cmd=000, busy=0, frame_done=0, overrun=0, index 0, and the registered vsync to 0.
REQ-029 Reset asserted mid-frame SHALL abandon the sequence without a frame_done pulse; the first frame start after release SHALL begin a new frame from index 0.
REQ-030 A vsync already high when reset releases SHALL NOT count as a frame start until it falls and rises again.

Configuration
REQ-031 With KEY_STEER_EN defined, the sprite 0 command SHALL be decoded from the captured keycode: 0x1A->UP, 0x16->DOWN, 0x04->LEFT, 0x07->RIGHT, any other value->HOLD.
REQ-032 Without KEY_STEER_EN, all commands SHALL be HOLD, and keycode SHALL be unused.

Verification
REQ-033 Mask 4'b1111, upd_ready=1, keycode 0x1A, KEY_STEER_EN defined, one vsync edge -> four handshakes with id 0,1,2,3, cmd 001,000,000,000, then a frame_done pulse 9 cycles after the edge cycle.
REQ-034 Mask 4'b1010, upd_ready low for 3 cycles on each request -> only ids 1 and 3 are issued, id/cmd stay stable while stalled, and frame_done pulses once.
REQ-035 Mask 4'b0000 -> upd_valid never rises; frame_done pulses at edge+2; busy is high for 2 cycles.
REQ-036 Second vsync edge while stalled in ISSUE -> overrun=1 and the sequence completes unchanged; clr_overrun together with a new overrun event -> overrun remains 1; clr_overrun alone -> overrun becomes 0.
REQ-037 Reset_n pulsed low while in ISSUE with id 2 -> upd_valid drops immediately with no frame_done; the next edge restarts at id 0.
REQ-038 Build without KEY_STEER_EN, keycode 0x07 -> sprite 0 cmd is 000.
